vec_accumulator: RTL and testbench



---
 rtl/vec_accumulator.sv | 174 +++++++++++++++++
 tb/tb_vec_accumulator.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vec_accumulator.sv
// -----------------------------------------------------------------------------
// vec_accumulator
//
// Streaming signed reduction stage. It takes signed samples over a valid/ready
// handshake, sums exactly VEC_LEN of them into a WIDTH_ACC-bit accumulator,
// arithmetically shifts the total right by SHIFT and emits one narrowed result
// per vector. The result is held until the consumer takes it. No samples are
// accepted while a result is pending.
//
// Optional feature (compile-time macro VEC_ACC_SAT_EN):
//   defined   : result clamped to the signed WIDTH_OUT range, out_sat flags it
//   undefined : result wraps (low WIDTH_OUT bits), out_sat tied to 0
//
// Parameter constraints: VEC_LEN >= 2, WIDTH_ACC >= WIDTH_IN + clog2(VEC_LEN).
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort: drops partial sum and pending result
//   in_valid   in   sample valid
//   in_ready   out  block can accept a sample (decode of state only)
//   in_data    in   [WIDTH_IN]  signed sample
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   out_data   out  [WIDTH_OUT] signed requantized result
//   out_sat    out  result was clamped
// -----------------------------------------------------------------------------
module vec_accumulator #(
  parameter int WIDTH_IN  = 8,
  parameter int VEC_LEN   = 16,
  parameter int WIDTH_ACC = 20,
  parameter int SHIFT     = 0,
  parameter int WIDTH_OUT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 out_sat
);

  localparam int CNT_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  // Common width for narrowing so the clamp compare works whether the output
  // is narrower or wider than the accumulator.
  localparam int RW    = (WIDTH_ACC > WIDTH_OUT) ? WIDTH_ACC : WIDTH_OUT;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic signed [WIDTH_ACC-1:0]   acc_q, acc_d;
  logic        [CNT_W-1:0]       cnt_q, cnt_d;
  logic        [WIDTH_OUT-1:0]   out_data_q, out_data_d;
  logic                          out_sat_q, out_sat_d;

  logic                          accept;
  logic                          last;
  logic signed [WIDTH_ACC-1:0]   in_ext;
  logic signed [WIDTH_ACC-1:0]   sum;
  logic signed [WIDTH_ACC-1:0]   res;
  logic signed [RW-1:0]          res_ext;
  logic        [WIDTH_OUT-1:0]   q_data;
  logic                          q_sat;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign accept  = in_valid && in_ready;
  assign last    = accept && (cnt_q == CNT_LAST);
  assign in_ext  = WIDTH_ACC'($signed(in_data));
  assign sum     = acc_q + in_ext;
  assign res     = sum >>> SHIFT;          // floor toward -inf
  assign res_ext = RW'(res);

`ifdef VEC_ACC_SAT_EN
  localparam logic signed [RW-1:0] OUT_MAX =
    {{(RW-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN = ~OUT_MAX;

  always_comb begin
    q_data = res_ext[WIDTH_OUT-1:0];
    q_sat  = 1'b0;
    if (res_ext > OUT_MAX) begin
      q_data = OUT_MAX[WIDTH_OUT-1:0];
      q_sat  = 1'b1;
    end else if (res_ext < OUT_MIN) begin
      q_data = OUT_MIN[WIDTH_OUT-1:0];
      q_sat  = 1'b1;
    end
  end
`else
  // Wrap-around: the bits above WIDTH_OUT are simply discarded.
  logic unused_res_hi;
  assign unused_res_hi = ^res_ext;
  assign q_data = res_ext[WIDTH_OUT-1:0];
  assign q_sat  = 1'b0;
`endif

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    if (clear) begin
      // Abort wins over everything, including a same-cycle sample.
      acc_d = '0;
      cnt_d = '0;
    end else if (last) begin
      acc_d      = '0;
      cnt_d      = '0;
      out_data_d = q_data;
      out_sat_d  = q_sat;
    end else if (accept) begin
      acc_d = sum;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (last)      state_d = HOLD;
        HOLD:    if (out_ready) state_d = ACCUM;
        default:                state_d = ACCUM;
      endcase
    end
  end

  // Handshake flags decode the registered state only, so there is no
  // combinational path from out_ready to in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM:   in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  assign out_data = out_data_q;
  assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_vec_accumulator.sv
module tb_vec_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = '0;

  logic       rdy0, rdy2, ov0, ov2, sat0, sat2;
  logic [7:0] od0, od2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vec_accumulator #(.WIDTH_IN(8), .VEC_LEN(4), .WIDTH_ACC(20), .SHIFT(0), .WIDTH_OUT(8)) u_s0 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(sat0));

  vec_accumulator #(.WIDTH_IN(8), .VEC_LEN(4), .WIDTH_ACC(20), .SHIFT(2), .WIDTH_OUT(8)) u_s2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(sat2));

  // samples a..d; wrap = expected without clamp, satv/satf = with clamp,
  // sh2 = expected for the SHIFT=2 instance (always in range)
  typedef struct {
    int a, b, c, d;
    int wrap;
    int satv;
    int satf;
    int sh2;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sample is taken.
  task automatic send(input int v);
    int t;
    in_valid = 1'b1;
    in_data  = 8'(v);
    t = 0;
    while (!rdy0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy0) chk("in_ready_timeout", int'(rdy0), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send4(input int a, input int b, input int c, input int d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic expect_res(input string nm, input int e0, input int f0, input int e2);
    int t;
    t = 0;
    while (!ov0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid"},  int'(ov0), 1);
    chk({nm, "_valid2"}, int'(ov2), 1);
    chk({nm, "_data"},   int'($signed(od0)), e0);
    chk({nm, "_sat"},    int'(sat0), f0);
    chk({nm, "_data2"},  int'($signed(od2)), e2);
    chk({nm, "_sat2"},   int'(sat2), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_release"}, int'(ov0), 0);
    chk({nm, "_reaccept"}, int'(rdy0), 1);
  endtask

  initial begin
    int e0, f0;

    tbl[0] = '{a:10,   b:20,   c:30,   d:40,  wrap:100,  satv:100,  satf:0, sh2:25};
    tbl[1] = '{a:127,  b:127,  c:127,  d:127, wrap:-4,   satv:127,  satf:1, sh2:127};
    tbl[2] = '{a:-128, b:-128, c:-128, d:-128,wrap:0,    satv:-128, satf:1, sh2:-128};
    tbl[3] = '{a:1,    b:2,    c:3,    d:4,   wrap:10,   satv:10,   satf:0, sh2:2};
    tbl[4] = '{a:-5,   b:0,    c:0,    d:0,   wrap:-5,   satv:-5,   satf:0, sh2:-2};
    tbl[5] = '{a:7,    b:0,    c:0,    d:0,   wrap:7,    satv:7,    satf:0, sh2:1};
    tbl[6] = '{a:-1,   b:-1,   c:-1,   d:-1,  wrap:-4,   satv:-4,   satf:0, sh2:-1};
    tbl[7] = '{a:100,  b:100,  c:-100, d:-50, wrap:50,   satv:50,   satf:0, sh2:12};
    tbl[8] = '{a:64,   b:64,   c:0,    d:0,   wrap:-128, satv:127,  satf:1, sh2:32};
    tbl[9] = '{a:-64,  b:-64,  c:-1,   d:0,   wrap:127,  satv:-128, satf:1, sh2:-33};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", int'(ov0), 0);
    chk("rst_out_data",  int'(od0), 0);
    chk("rst_out_sat",   int'(sat0), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(rdy0), 1);

    // basic sum with backpressure; a sample offered during HOLD is ignored
    send4(10, 20, 30, 40);
    chk("bp_latency", int'(ov0), 1);
    in_valid = 1'b1;
    in_data  = 8'd99;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", int'(ov0), 1);
      chk("bp_hold_data",  int'($signed(od0)), 100);
      chk("bp_hold_ready", int'(rdy0), 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    expect_res("bp", 100, 0, 25);

    // table-driven vectors, out_ready taken one cycle after result
    for (int i = 0; i < 10; i++) begin
`ifdef VEC_ACC_SAT_EN
      e0 = tbl[i].satv;
      f0 = tbl[i].satf;
`else
      e0 = tbl[i].wrap;
      f0 = 0;
`endif
      send4(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
      chk($sformatf("v%0d_latency", i), int'(ov0), 1);
      expect_res($sformatf("v%0d", i), e0, f0, tbl[i].sh2);
    end

    // clear mid-vector, with a sample in the clear cycle that must be dropped
    send(50);
    send(50);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i == 3) chk("clr_no_early", int'(ov0), 0);
      send(1);
    end
    expect_res("clr_mid", 4, 0, 1);

    // clear while a result is pending: it is never delivered
    send4(5, 5, 5, 5);
    chk("clr_hold_pending", int'(ov0), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_hold_drop",  int'(ov0), 0);
    chk("clr_hold_ready", int'(rdy0), 1);
    repeat (3) begin
      @(negedge clk);
      chk("clr_hold_quiet", int'(ov0), 0);
    end
    send4(3, 3, 3, 3);
    expect_res("clr_hold_next", 12, 0, 3);

    // asynchronous reset mid-vector
    send(9); send(9); send(9);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(ov0), 0);
    chk("arst_data",  int'(od0), 0);
    chk("arst_sat",   int'(sat0), 0);
    chk("arst_data2", int'(od2), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ready", int'(rdy0), 1);
    send4(2, 2, 2, 2);
    expect_res("arst_after", 8, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
